// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Multi-cycle subtractor. It computes diff = a - b - bin (mod 2^WIDTH). Each cycle it takes
// SLICE bits, starting from the least significant end.
//
// Parameters
//   WIDTH  operand/result width in bits (2..64)
//   SLICE  bits processed per cycle; WIDTH must be a multiple of SLICE
//
// Ports
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset
//   start  capture a/b/bin and begin; honoured only while idle
//   a, b   minuend and subtrahend
//   bin    borrow-in
//   diff   registered result a - b - bin
//   bout   borrow out of the MSB
//   ovf    two's-complement overflow
//   zero   diff == 0
//   busy   high while the subtraction is in progress
//   done   one-cycle pulse when a new result appears on the outputs
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be in 2..64");
  end
  if (SLICE == 0 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("serial_subtractor: SLICE must divide WIDTH");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             brw_q, brw_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // The slice datapath is a rippled full-subtractor chain. It works on the low SLICE bits of the
  // operand shift registers.
  logic [SLICE-1:0] slice_diff;
  logic             slice_bout;
  logic             slice_msb_bin;  // borrow into the top bit of this slice
  logic [WIDTH-1:0] res_shifted;

  always_comb begin
    logic c;
    logic x;
    logic y;
    slice_diff    = '0;
    slice_msb_bin = 1'b0;
    c             = brw_q;
    for (int i = 0; i < SLICE; i++) begin
      x             = a_sh_q[i];
      y             = b_sh_q[i];
      slice_msb_bin = c;
      slice_diff[i] = x ^ y ^ c;
      c             = (~x & y) | (~x & c) | (y & c);
    end
    slice_bout = c;
  end

  // New slice bits enter the result register at the top. After N shifts the first slice has
  // reached bit 0.
  always_comb begin
    logic [WIDTH-1:0] slice_ext;
    slice_ext              = '0;
    slice_ext[SLICE-1:0]   = slice_diff;
    res_shifted            = (res_sh_q >> SLICE) | (slice_ext << (WIDTH - SLICE));
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          brw_d    = bin;
          res_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d   = a_sh_q >> SLICE;
        b_sh_d   = b_sh_q >> SLICE;
        res_sh_d = res_shifted;
        brw_d    = slice_bout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // The final slice holds the MSB. All result outputs update together on this edge.
          state_d = DONE;
          diff_d  = res_shifted;
          bout_d  = slice_bout;
          ovf_d   = slice_msb_bin ^ slice_bout;
          zero_d  = (res_shifted == '0);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//
// Two instances share clk and rst_n:
//   - a bit-serial instance (WIDTH=8, SLICE=1)
//   - a nibble-serial instance (WIDTH=8, SLICE=4)
// Results are compared against an integer-arithmetic model of a - b - bin.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start4;
  logic [7:0] a1, b1, a4, b4;
  logic       bin1, bin4;
  logic [7:0] diff1, diff4;
  logic       bout1, ovf1, zero1, busy1, done1;
  logic       bout4, ovf4, zero4, busy4, done4;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_diff [2];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .SLICE(1)) u_dut1 (
    .clk  (clk),   .rst_n(rst_n), .start(start1),
    .a    (a1),    .b    (b1),    .bin  (bin1),
    .diff (diff1), .bout (bout1), .ovf  (ovf1),
    .zero (zero1), .busy (busy1), .done (done1)
  );

  serial_subtractor #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk  (clk),   .rst_n(rst_n), .start(start4),
    .a    (a4),    .b    (b4),    .bin  (bin4),
    .diff (diff4), .bout (bout4), .ovf  (ovf4),
    .zero (zero4), .busy (busy4), .done (done4)
  );

  // Reference: {zero, ovf, bout, diff}, from plain signed/unsigned integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic mbin);
    int ua, ub, sa, sb, cb, r, sr;
    logic [7:0] d;
    logic bo, ov, z;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    cb = mbin ? 1 : 0;
    r  = ua - ub - cb;
    sr = sa - sb - cb;
    d  = r[7:0];
    bo = (r < 0);
    ov = (sr > 127) || (sr < -128);
    z  = (d == 8'h00);
    return {z, ov, bo, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] da, input logic [7:0] db,
                       input logic dbin, input logic dst);
    if (sel == 0) begin
      a1 = da; b1 = db; bin1 = dbin; start1 = dst;
    end else begin
      a4 = da; b4 = db; bin4 = dbin; start4 = dst;
    end
  endtask

  task automatic get_out(input int sel, output logic [7:0] d, output logic bo,
                         output logic ov, output logic z, output logic bs, output logic dn);
    if (sel == 0) begin
      d = diff1; bo = bout1; ov = ovf1; z = zero1; bs = busy1; dn = done1;
    end else begin
      d = diff4; bo = bout4; ov = ovf4; z = zero4; bs = busy4; dn = done4;
    end
  endtask

  // One full operation. Operand inputs are scrambled after capture. If mid_start is nonzero,
  // start is pulsed again during RUN, on cycle mid_start.
  task automatic run_op(input int sel, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tbin, input int mid_start);
    logic [10:0] m;
    logic [7:0]  d;
    logic        bo, ov, z, bs, dn;
    int          n, cyc;
    n = (sel == 0) ? 8 : 2;
    m = model(ta, tb_, tbin);
    @(negedge clk);
    drive(sel, ta, tb_, tbin, 1'b1);
    @(posedge clk);
    #1;
    drive(sel, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    get_out(sel, d, bo, ov, z, bs, dn);
    cyc = 0;
    while (bs && cyc < 20) begin
      cyc++;
      check("hold_diff", 64'(d), 64'(last_diff[sel]));
      check("no_done_in_run", 64'(dn), 64'(0));
      drive(sel, 8'($urandom), 8'($urandom), 1'($urandom), (cyc == mid_start) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      get_out(sel, d, bo, ov, z, bs, dn);
    end
    drive(sel, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    check("busy_cycles", 64'(cyc), 64'(n));
    check("done_pulse", 64'(dn), 64'(1));
    check("diff", 64'(d), 64'(m[7:0]));
    check("bout", 64'(bo), 64'(m[8]));
    check("ovf", 64'(ov), 64'(m[9]));
    check("zero", 64'(z), 64'(m[10]));
    last_diff[sel] = m[7:0];
    @(posedge clk);
    #1;
    get_out(sel, d, bo, ov, z, bs, dn);
    check("done_one_cycle", 64'(dn), 64'(0));
    check("idle_after_done", 64'(bs), 64'(0));
    check("diff_held_after", 64'(d), 64'(m[7:0]));
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 8'h00, 8'h00, 1'b0, 1'b0);
    last_diff[0] = 8'h00;
    last_diff[1] = 8'h00;

    // Reset has priority over start.
    start1 = 1'b1;
    start4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy1", 64'(busy1), 64'(0));
    check("rst_done1", 64'(done1), 64'(0));
    check("rst_diff1", 64'(diff1), 64'(0));
    check("rst_flags1", 64'({bout1, ovf1, zero1}), 64'(0));
    check("rst_busy4", 64'(busy4), 64'(0));
    check("rst_diff4", 64'({diff4, bout4, ovf4, zero4, done4}), 64'(0));
    start1 = 1'b0;
    start4 = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    check("idle_no_start", 64'(busy1), 64'(0));

    // Directed cases.
    run_op(0, 8'h05, 8'h03, 1'b0, 0);
    run_op(0, 8'h00, 8'h01, 1'b0, 0);
    run_op(0, 8'h80, 8'h01, 1'b0, 0);
    run_op(0, 8'h10, 8'h0F, 1'b1, 0);
    run_op(0, 8'h7F, 8'hFF, 1'b1, 0);
    run_op(0, 8'hAA, 8'h55, 1'b0, 3);   // start again mid-RUN must be ignored
    run_op(1, 8'h3C, 8'hC3, 1'b0, 0);
    run_op(1, 8'h80, 8'h00, 1'b1, 1);

    // Abort by reset on RUN cycle 4.
    @(negedge clk);
    drive(0, 8'h12, 8'h34, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy1), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_busy", 64'(busy1), 64'(0));
    check("abort_done", 64'(done1), 64'(0));
    check("abort_diff", 64'(diff1), 64'(0));
    check("abort_bout", 64'(bout1), 64'(0));
    last_diff[0] = 8'h00;
    last_diff[1] = 8'h00;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done1 || busy1) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'(0));

    // First operation after reset behaves as from power-up.
    run_op(0, 8'h05, 8'h03, 1'b0, 0);

    // Randomized operations on both configurations.
    for (int i = 0; i < 30; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 0);
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
